// File: rtl/io_stage_load_align.sv
// IO (memory-access) pipeline stage: holds one beat between EX and WB, waits for
// variable-latency data-SRAM responses, aligns sub-word loads and drives the ID bypass.
//
// state   | meaning
// --------+----------------------------------------------------------
// EMPTY   | no valid beat held
// WAIT    | beat issued a data request, response not yet consumed
// DONE    | non-load beat, or load data captured in the hold register
module io_stage_load_align #(
    parameter int PC_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DISCARD_WIDTH  = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wb_allow_in,
    output logic                      io_allow_in,
    input  logic                      ex_valid,
    input  logic [PC_WIDTH-1:0]       ex_pc,
    input  logic [31:0]               ex_alu_result,
    input  logic [2:0]                ex_load_op,
    input  logic [31:0]               ex_rt_value,
    input  logic [REG_ADDR_WIDTH-1:0] ex_dest,
    input  logic                      ex_reg_write,
    input  logic                      ex_req_issued,
    input  logic                      data_data_ok,
    input  logic [31:0]               data_rdata,
    input  logic                      flush,
    output logic                      io_to_wb_valid,
    output logic [PC_WIDTH-1:0]       io_pc,
    output logic [31:0]               io_result,
    output logic [REG_ADDR_WIDTH-1:0] io_dest,
    output logic                      io_reg_write,
    output logic                      bp_valid,
    output logic [REG_ADDR_WIDTH-1:0] bp_dest,
    output logic [31:0]               bp_data,
    output logic                      bp_pending
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                    state, state_nxt;
    logic [DISCARD_WIDTH-1:0]  discard_cnt, discard_nxt;
    logic [PC_WIDTH-1:0]       pc_q;
    logic [31:0]               alu_q;
    logic [2:0]                op_q;
    logic [31:0]               rt_q;
    logic [REG_ADDR_WIDTH-1:0] dest_q;
    logic                      we_q;
    logic [31:0]               hold_q;

    logic        io_valid;
    logic        data_hit;
    logic        ready_go;
    logic        accept;
    logic        orphan_new;
    logic        orphan_drop;
    logic [31:0] load_word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign io_valid    = (state != ST_EMPTY);
    assign data_hit    = (state == ST_WAIT) && data_data_ok && (discard_cnt == '0);
    assign ready_go    = (state == ST_DONE) || data_hit;
    assign io_allow_in = !io_valid || (ready_go && wb_allow_in);
    assign accept      = ex_valid && io_allow_in && !flush;

    // A killed WAIT beat leaves its response orphaned unless that response is consumed now.
    assign orphan_new  = flush && (state == ST_WAIT) && !data_hit;
    assign orphan_drop = data_data_ok && (discard_cnt != '0);

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = ST_EMPTY;
        else if (io_allow_in)
            state_nxt = !ex_valid ? ST_EMPTY : (ex_req_issued ? ST_WAIT : ST_DONE);
        else if (data_hit)
            state_nxt = ST_DONE;
    end

    always_comb begin
        discard_nxt = discard_cnt;
        if (orphan_new && !orphan_drop && (discard_cnt != '1))
            discard_nxt = discard_cnt + 1'b1;
        else if (orphan_drop && !orphan_new)
            discard_nxt = discard_cnt - 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_EMPTY;
            discard_cnt <= '0;
            hold_q      <= '0;
            pc_q        <= '0;
            alu_q       <= '0;
            op_q        <= '0;
            rt_q        <= '0;
            dest_q      <= '0;
            we_q        <= 1'b0;
        end else begin
            state       <= state_nxt;
            discard_cnt <= discard_nxt;
            if (data_hit)
                hold_q <= data_rdata;
            if (accept) begin
                pc_q   <= ex_pc;
                alu_q  <= ex_alu_result;
                op_q   <= ex_load_op;
                rt_q   <= ex_rt_value;
                dest_q <= ex_dest;
                we_q   <= ex_reg_write;
            end
        end
    end

    // Same-cycle response bypasses the hold register for zero added latency.
    assign load_word = data_hit ? data_rdata : hold_q;

    always_comb begin
        sel_byte = load_word[7:0];
        case (alu_q[1:0])
            2'd1:    sel_byte = load_word[15:8];
            2'd2:    sel_byte = load_word[23:16];
            2'd3:    sel_byte = load_word[31:24];
            default: sel_byte = load_word[7:0];
        endcase
        sel_half = alu_q[1] ? load_word[31:16] : load_word[15:0];
    end

    always_comb begin
        io_result = alu_q;
        case (op_q)
            3'd1: io_result = {{24{sel_byte[7]}}, sel_byte};
            3'd2: io_result = {24'd0, sel_byte};
            3'd3: io_result = {{16{sel_half[15]}}, sel_half};
            3'd4: io_result = {16'd0, sel_half};
            3'd5: io_result = load_word;
            3'd6: begin
                case (alu_q[1:0])
                    2'd0:    io_result = {load_word[7:0], rt_q[23:0]};
                    2'd1:    io_result = {load_word[15:0], rt_q[15:0]};
                    2'd2:    io_result = {load_word[23:0], rt_q[7:0]};
                    default: io_result = load_word;
                endcase
            end
            3'd7: begin
                case (alu_q[1:0])
                    2'd0:    io_result = load_word;
                    2'd1:    io_result = {rt_q[31:24], load_word[31:8]};
                    2'd2:    io_result = {rt_q[31:16], load_word[31:16]};
                    default: io_result = {rt_q[31:8], load_word[31:24]};
                endcase
            end
            default: io_result = alu_q;
        endcase
    end

    assign io_to_wb_valid = io_valid && ready_go;
    assign io_pc          = pc_q;
    assign io_dest        = dest_q;
    assign io_reg_write   = we_q;
    assign bp_valid       = io_valid && we_q && (dest_q != '0);
    assign bp_dest        = dest_q;
    assign bp_data        = io_result;
    assign bp_pending     = bp_valid && (state == ST_WAIT) && !data_hit;

endmodule

// File: tb/tb_io_stage_load_align.sv
// Bench for io_stage_load_align: directed scenarios plus randomized traffic, with a
// scoreboard fed at beat acceptance and drained by a WB-side monitor.
module tb_io_stage_load_align;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_allow_in;
    logic        io_allow_in;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_alu_result;
    logic [2:0]  ex_load_op;
    logic [31:0] ex_rt_value;
    logic [4:0]  ex_dest;
    logic        ex_reg_write;
    logic        ex_req_issued;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        flush;
    logic        io_to_wb_valid;
    logic [31:0] io_pc;
    logic [31:0] io_result;
    logic [4:0]  io_dest;
    logic        io_reg_write;
    logic        bp_valid;
    logic [4:0]  bp_dest;
    logic [31:0] bp_data;
    logic        bp_pending;

    io_stage_load_align #(.PC_WIDTH(32), .REG_ADDR_WIDTH(5), .DISCARD_WIDTH(2)) dut (
        .clock(clock), .reset(reset), .wb_allow_in(wb_allow_in), .io_allow_in(io_allow_in),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_result(ex_alu_result),
        .ex_load_op(ex_load_op), .ex_rt_value(ex_rt_value), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_req_issued(ex_req_issued),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .flush(flush),
        .io_to_wb_valid(io_to_wb_valid), .io_pc(io_pc), .io_result(io_result),
        .io_dest(io_dest), .io_reg_write(io_reg_write), .bp_valid(bp_valid),
        .bp_dest(bp_dest), .bp_data(bp_data), .bp_pending(bp_pending)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        we;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] resp_q[$];
    logic [31:0] next_rdata;
    bit          held;
    int          n_cmp  = 0;
    int          n_fail = 0;

    logic [2:0]  t_op  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    logic [1:0]  t_off [6] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [31:0] t_rd  [6] = '{32'h80112233, 32'h80112233, 32'h80112233, 32'h80112233,
                               32'hAABBCCDD, 32'hAABBCCDD};
    logic [31:0] t_exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00002233,
                               32'hCCDD3344, 32'h1122AABB};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: MIPS little-endian load semantics expressed as shifts and masks.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] rd, input logic [31:0] rt,
                                             input logic [31:0] alu);
        int          o = int'(off);
        logic [31:0] v;
        logic [31:0] m;
        case (op)
            3'd1: begin v = (rd >> (8*o)) & 32'hFF; return v[7] ? (v | 32'hFFFFFF00) : v; end
            3'd2: return (rd >> (8*o)) & 32'hFF;
            3'd3: begin v = (rd >> (16*(o/2))) & 32'hFFFF; return v[15] ? (v | 32'hFFFF0000) : v; end
            3'd4: return (rd >> (16*(o/2))) & 32'hFFFF;
            3'd5: return rd;
            3'd6: begin
                if (o == 3) return rd;
                m = (32'h1 << (8*(3-o))) - 32'h1;
                return (rd << (8*(3-o))) | (rt & m);
            end
            3'd7: begin
                m = 32'hFFFFFFFF >> (8*o);
                return (rd >> (8*o)) | (rt & ~m);
            end
            default: return alu;
        endcase
    endfunction

    // Issue side: record accepted beats and the response order of issued requests.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            sb.delete();
            resp_q.delete();
            held = 1'b0;
        end else begin
            if (data_data_ok && resp_q.size() > 0)
                void'(resp_q.pop_front());
            if (flush) begin
                if (held) void'(sb.pop_back());
                held = 1'b0;
            end else begin
                if (io_to_wb_valid && wb_allow_in) held = 1'b0;
                if (ex_valid && io_allow_in) begin
                    e.pc     = ex_pc;
                    e.result = ref_load(ex_load_op, ex_alu_result[1:0], next_rdata,
                                        ex_rt_value, ex_alu_result);
                    e.dest   = ex_dest;
                    e.we     = ex_reg_write;
                    sb.push_back(e);
                    held = 1'b1;
                    if (ex_req_issued) resp_q.push_back(next_rdata);
                end
            end
        end
    end

    // WB side monitor.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && io_to_wb_valid && wb_allow_in) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_beat: pc 0x%08h result 0x%08h, none expected",
                         io_pc, io_result);
            end else begin
                e = sb.pop_front();
                chk("wb_result", io_result, e.result);
                chk("wb_pc", io_pc, e.pc);
                chk("wb_dest_we", {26'd0, io_dest, io_reg_write}, {26'd0, e.dest, e.we});
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        ex_valid      = 1'b0;
        ex_req_issued = 1'b0;
        data_data_ok  = 1'b0;
        flush         = 1'b0;
        wb_allow_in   = 1'b1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [2:0] op,
                         input logic [31:0] rt, input logic [4:0] dest, input logic we,
                         input logic req, input logic [31:0] rd);
        ex_valid      = 1'b1;
        ex_pc         = pc;
        ex_alu_result = alu;
        ex_load_op    = op;
        ex_rt_value   = rt;
        ex_dest       = dest;
        ex_reg_write  = we;
        ex_req_issued = req;
        next_rdata    = rd;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $finish;
    end

    initial begin
        reset = 1'b1;
        idle_in();
        ex_pc = '0; ex_alu_result = '0; ex_load_op = '0; ex_rt_value = '0;
        ex_dest = '0; ex_reg_write = 1'b0; data_rdata = '0; next_rdata = '0;
        @(negedge clock);
        chk("reset_allow_in", {31'd0, io_allow_in}, 32'd1);
        chk("reset_to_wb_valid", {31'd0, io_to_wb_valid}, 32'd0);
        chk("reset_bp_valid", {31'd0, bp_valid}, 32'd0);
        chk("reset_io_result", io_result, 32'd0);
        chk("reset_io_pc", io_pc, 32'd0);
        cyc();
        reset = 1'b0;

        // lw with a three-cycle response latency
        issue(32'h100, 32'h100, 3'd5, 32'd0, 5'd3, 1'b1, 1'b1, 32'hDEADBEEF);
        cyc(); idle_in();
        @(negedge clock);
        chk("lw_wait1_valid", {31'd0, io_to_wb_valid}, 32'd0);
        chk("lw_wait1_pending", {31'd0, bp_pending}, 32'd1);
        cyc();
        @(negedge clock);
        chk("lw_wait2_valid", {31'd0, io_to_wb_valid}, 32'd0);
        chk("lw_wait2_pending", {31'd0, bp_pending}, 32'd1);
        cyc(); data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
        @(negedge clock);
        chk("lw_data_valid", {31'd0, io_to_wb_valid}, 32'd1);
        chk("lw_data_result", io_result, 32'hDEADBEEF);
        chk("lw_data_pending", {31'd0, bp_pending}, 32'd0);
        cyc(); idle_in();
        @(negedge clock);
        chk("lw_after_valid", {31'd0, io_to_wb_valid}, 32'd0);

        // sub-word alignment table
        for (int i = 0; i < 6; i++) begin
            cyc();
            issue(32'h200 + 32'(i*4), 32'h200 | {30'd0, t_off[i]}, t_op[i], 32'h11223344,
                  5'(i + 5), 1'b1, 1'b1, t_rd[i]);
            cyc(); idle_in(); data_data_ok = 1'b1; data_rdata = t_rd[i];
            @(negedge clock);
            chk($sformatf("align_%0d", i), io_result, t_exp[i]);
        end

        // response arrives under a two-cycle WB stall, ALU beat blocked behind it
        cyc(); idle_in();
        issue(32'h300, 32'h300, 3'd5, 32'd0, 5'd6, 1'b1, 1'b1, 32'hDEADBEEF);
        cyc(); idle_in(); data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF; wb_allow_in = 1'b0;
        issue(32'h304, 32'h12345678, 3'd0, 32'd0, 5'd7, 1'b1, 1'b0, 32'd0);
        @(negedge clock);
        chk("stall1_valid", {31'd0, io_to_wb_valid}, 32'd1);
        chk("stall1_allow", {31'd0, io_allow_in}, 32'd0);
        chk("stall1_result", io_result, 32'hDEADBEEF);
        cyc(); data_data_ok = 1'b0; data_rdata = 32'h0BADF00D;
        @(negedge clock);
        chk("stall2_allow", {31'd0, io_allow_in}, 32'd0);
        chk("stall2_hold_result", io_result, 32'hDEADBEEF);
        cyc(); wb_allow_in = 1'b1;
        @(negedge clock);
        chk("stall_release_allow", {31'd0, io_allow_in}, 32'd1);
        cyc(); idle_in();
        @(negedge clock);
        chk("alu_after_stall_valid", {31'd0, io_to_wb_valid}, 32'd1);
        chk("alu_after_stall_result", io_result, 32'h12345678);

        // flush during WAIT orphans one response
        cyc(); idle_in();
        issue(32'h400, 32'h400, 3'd5, 32'd0, 5'd8, 1'b1, 1'b1, 32'h1);
        cyc(); idle_in(); flush = 1'b1; wb_allow_in = 1'b0;
        cyc(); idle_in();
        issue(32'h404, 32'h404, 3'd5, 32'd0, 5'd9, 1'b1, 1'b1, 32'h2);
        cyc(); idle_in(); data_data_ok = 1'b1; data_rdata = 32'h1;
        @(negedge clock);
        chk("orphan_dropped_valid", {31'd0, io_to_wb_valid}, 32'd0);
        chk("orphan_dropped_pending", {31'd0, bp_pending}, 32'd1);
        cyc(); data_data_ok = 1'b1; data_rdata = 32'h2;
        @(negedge clock);
        chk("after_orphan_valid", {31'd0, io_to_wb_valid}, 32'd1);
        chk("after_orphan_result", io_result, 32'h2);

        // asynchronous reset mid-WAIT with an orphan outstanding
        cyc(); idle_in();
        issue(32'h500, 32'h500, 3'd5, 32'd0, 5'd10, 1'b1, 1'b1, 32'h55);
        cyc(); idle_in(); flush = 1'b1; wb_allow_in = 1'b0;
        cyc(); idle_in();
        issue(32'h504, 32'h504, 3'd5, 32'd0, 5'd11, 1'b1, 1'b1, 32'h66);
        cyc(); idle_in();
        @(negedge clock);
        chk("pre_reset_bp_valid", {31'd0, bp_valid}, 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("async_reset_bp_valid", {31'd0, bp_valid}, 32'd0);
        chk("async_reset_to_wb_valid", {31'd0, io_to_wb_valid}, 32'd0);
        chk("async_reset_allow_in", {31'd0, io_allow_in}, 32'd1);
        chk("async_reset_pending", {31'd0, bp_pending}, 32'd0);
        @(negedge clock);
        cyc(); reset = 1'b0;
        issue(32'h600, 32'h600, 3'd5, 32'd0, 5'd12, 1'b1, 1'b1, 32'h77);
        cyc(); idle_in(); data_data_ok = 1'b1; data_rdata = 32'h77;
        @(negedge clock);
        chk("post_reset_valid", {31'd0, io_to_wb_valid}, 32'd1);
        chk("post_reset_result", io_result, 32'h77);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [2:0] op;
            cyc();
            flush       = ($urandom_range(0, 15) == 0);
            wb_allow_in = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            if (op != 3'd0 && resp_q.size() >= 3) op = 3'd0;
            ex_valid      = ($urandom_range(0, 1) == 1);
            ex_pc         = $urandom;
            ex_alu_result = $urandom;
            ex_load_op    = op;
            ex_rt_value   = $urandom;
            ex_dest       = 5'($urandom_range(0, 31));
            ex_reg_write  = ($urandom_range(0, 3) != 0);
            ex_req_issued = (op != 3'd0);
            next_rdata    = $urandom;
            if (resp_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                data_data_ok = 1'b1;
                data_rdata   = resp_q[0];
            end else begin
                data_data_ok = 1'b0;
                data_rdata   = $urandom;
            end
        end

        for (int k = 0; k < 200 && (sb.size() != 0 || resp_q.size() != 0); k++) begin
            cyc(); idle_in();
            if (resp_q.size() > 0) begin
                data_data_ok = 1'b1;
                data_rdata   = resp_q[0];
            end
        end
        cyc(); idle_in();
        @(negedge clock);
        chk("drain_scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("drain_responses_empty", 32'(resp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
